seq_ctx_sched: RTL
==================

// Module: seq_ctx_sched
// PURPOSE
//  Time-multiplexes one 4-state Mealy sequence engine (states S0..S3, input C, output Y)
//  across NCH independent bit streams. Each channel keeps a saved 2-bit state context.
//  A round-robin scheduler grants one channel per cycle and reads that channel's context.
//  It applies the transition, writes the context back and emits a registered Y tagged
//  with the channel id.
//  Sits between the per-channel bit sources and the downstream event collector.
// PARAMETERS
//  NCH   4   number of channels, 2..16
//  CW    2   channel-id width, must equal clog2(NCH)
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst_n      in   1        synchronous, active-low reset
//  ch_valid   in   NCH      channel i has a bit on ch_bit[i]
//  ch_bit     in   NCH      input bit C for channel i
//  ch_ready   out  NCH      grant: bit i consumed this cycle (one-hot or zero; combinational)
//  ch_clr     in   NCH      force channel i context to S0 at next edge
//  out_valid  out  1        result register holds a result
//  out_ready  in   1        downstream accepts the result
//  out_ch     out  CW       channel id of the result
//  out_y      out  1        Y for that step
//  ctx_state  out  2*NCH    saved contexts, {ch[NCH-1],...,ch[0]}, for observability
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - all contexts = S0 (2'd0)
//   - out_valid=0, out_ch=0, out_y=0
//   - RR pointer = NCH-1, so channel 0 has top priority first
//  Engine, per granted channel. Context cs, input C gives next state and Y:
//   - S0(0): C=1 goes to S1, else stays S0. Y=0.
//   - S1(1): C=0 goes to S3, else stays S1. Y=0.
//   - S3(3): C=1 goes to S2, else stays S3. Y=1.
//   - S2(2): C=0 goes to S0, else stays S2. Y=C.
//  Slot free: free = !out_valid || out_ready. No grant when free=0; all ch_ready=0.
//  Arbitration:
//   - When free, grant the first i with ch_valid[i]=1 and ch_clr[i]=0.
//   - Search order is ptr+1, ptr+2, ... modulo NCH.
//   - On a grant, ptr <= granted index. With no grant, ptr holds.
//  Latency and handshake:
//   - Granted at edge k: ctx[i] <= next, out_valid <= 1, out_ch <= i, out_y <= Y, all at edge k.
//   - The result is visible in the cycle after the grant.
//   - A result holds stable while out_valid && !out_ready.
//   - With out_valid && out_ready and no new grant, out_valid <= 0.
//   - Full throughput: one result per cycle while out_ready=1.
//  Back-to-back grants to the same channel see the written-back context; no hazard.
//  ch_clr[i]:
//   - ctx[i] <= S0.
//   - Clear beats grant: channel i is not granted that cycle and its bit stays pending.
//   - Other channels are unaffected.
//  Contexts of non-granted, non-cleared channels hold.
//  Mid-operation reset overrides everything, and a pending result is dropped.
// TESTING
//  1. Single channel: ch0 bits 1,0,1,0 with out_ready=1.
//     -> out_y 0,0,1,0; ctx0 ends at S0; out_ch=0 each cycle; 1-cycle latency.
//  2. S2 Mealy check: drive ch1 to S2 with 1,0,1, then send 1, then 0.
//     -> Y=1 while staying in S2, then Y=0 and state goes to S0.
//  3. Round-robin, NCH=4: all ch_valid=1 for 8 cycles.
//     -> grants 0,1,2,3,0,1,2,3; contexts advance independently.
//  4. Backpressure: out_ready=0 for 3 cycles while ch_valid=4'b1111.
//     -> out held stable, ch_ready=0, ctx unchanged; after release, RR resumes at the next index.
//  5. Clear vs grant: ch_clr[2]=1 and ch_valid[2]=1 when ch2 is the RR winner.
//     -> ch2 not granted, ctx2=S0, ch3 granted instead.
//  6. Reset mid-stream: rst_n=0 with out_valid=1 and contexts nonzero.
//     -> next cycle out_valid=0, ctx_state=0, first grant goes to ch0.

Source files
------------

// File: rtl/seq_ctx_sched.sv
// Time-multiplexed 4-state Mealy sequence engine shared by NCH bit streams.
// Round-robin grant per cycle, per-channel saved context, registered tagged result.
module seq_ctx_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [NCH-1:0]   ch_bit,
    output logic [NCH-1:0]   ch_ready,
    input  logic [NCH-1:0]   ch_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_ch,
    output logic             out_y,
    output logic [2*NCH-1:0] ctx_state
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } eng_state_t;

    eng_state_t        ctx_q [NCH];
    eng_state_t        ctx_d [NCH];
    logic [CW-1:0]     ptr_q;
    logic [CW-1:0]     ptr_d;
    logic              out_valid_d;
    logic [CW-1:0]     out_ch_d;
    logic              out_y_d;

    logic              free;
    logic [NCH-1:0]    eligible;
    logic              gnt_any;
    logic [CW-1:0]     gnt_idx;
    logic [CW-1:0]     idx;

    eng_state_t        cur_state;
    eng_state_t        nxt_state;
    logic              cur_c;
    logic              cur_y;

    // Round-robin search starting just after the last granted channel.
    // A channel being cleared this cycle is never eligible.
    always_comb begin
        free     = !out_valid || out_ready;
        eligible = ch_valid & ~ch_clr;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        idx      = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = CW'((32'(ptr_q) + k) % NCH);
            if (!gnt_any && free && eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        if (gnt_any) begin
            ch_ready[gnt_idx] = 1'b1;
        end
    end

    // Mealy transition for the granted channel's saved context.
    always_comb begin
        cur_state = ctx_q[gnt_idx];
        cur_c     = ch_bit[gnt_idx];
        nxt_state = cur_state;
        cur_y     = 1'b0;
        case (cur_state)
            S0: begin
                nxt_state = cur_c ? S1 : S0;
                cur_y     = 1'b0;
            end
            S1: begin
                nxt_state = cur_c ? S1 : S3;
                cur_y     = 1'b0;
            end
            S3: begin
                nxt_state = cur_c ? S2 : S3;
                cur_y     = 1'b1;
            end
            S2: begin
                nxt_state = cur_c ? S2 : S0;
                cur_y     = cur_c;
            end
            default: begin
                nxt_state = S0;
                cur_y     = 1'b0;
            end
        endcase
    end

    // Context write-back: clear wins over a step for the same channel.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ctx_d[i] = ctx_q[i];
            if (ch_clr[i]) begin
                ctx_d[i] = S0;
            end else if (gnt_any && (gnt_idx == CW'(i))) begin
                ctx_d[i] = nxt_state;
            end
        end
    end

    // Result slot: load on grant, hold under backpressure, drain on accept.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid && !out_ready;
        out_ch_d    = out_ch;
        out_y_d     = out_y;
        if (gnt_any) begin
            ptr_d       = gnt_idx;
            out_valid_d = 1'b1;
            out_ch_d    = gnt_idx;
            out_y_d     = cur_y;
        end
    end

    always_comb begin
        ctx_state = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ctx_state[2*i +: 2] = ctx_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ctx_q[i] <= S0;
            end
            ptr_q     <= CW'(NCH - 1);
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_y     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q     <= ptr_d;
            out_valid <= out_valid_d;
            out_ch    <= out_ch_d;
            out_y     <= out_y_d;
        end
    end

endmodule
